// File: rtl/pla_bist_ctrl.sv
// rtl/pla_bist_ctrl.sv - self-test engine for the 4-in/4-out PLA
// Drives exhaustive then LFSR vectors, checks against a host-loaded table, compacts responses in a MISR.
module pla_bist_ctrl #(
  parameter int unsigned SETTLE_CYC = 1,
  parameter int unsigned RAND_VECS  = 16,
  parameter logic [3:0]  LFSR_SEED  = 4'b0001
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       exp_we,
  input  logic [3:0] exp_addr,
  input  logic [3:0] exp_data,
  input  logic       start,
  output logic [3:0] pla_in,
  input  logic [3:0] pla_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [3:0] first_err_vec,
  output logic [3:0] first_err_got,
  output logic [3:0] signature
);

  localparam int unsigned NUM_VECS = 16 + RAND_VECS;
  localparam int unsigned VW = $clog2(NUM_VECS);
  localparam logic [VW-1:0] LAST_VEC = VW'(NUM_VECS - 1);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, FINISH} state_t;

  state_t        state, state_nxt;
  logic [3:0]    exp_tbl [16];
  logic [3:0]    lfsr;
  logic [3:0]    lfsr_next;
  logic [3:0]    wait_cnt;
  logic [VW-1:0] vec_cnt;
  logic          settle_end, last_vec, mismatch;
  logic          idle, run_start, tbl_we, do_check, advance, finish;

  assign settle_end = (wait_cnt == SETTLE_LAST);
  assign last_vec   = (vec_cnt == LAST_VEC);
  assign mismatch   = (pla_out != exp_tbl[pla_in]);
  assign lfsr_next  = {lfsr[2:0], lfsr[3] ^ lfsr[2]};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SETTLE;
      SETTLE:  if (settle_end) state_nxt = CHECK;
      CHECK:   state_nxt = last_vec ? FINISH : SETTLE;
      FINISH:  state_nxt = start ? SETTLE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FINISH is the first idle cycle after a run, so it accepts start and table writes like IDLE.
  always_comb begin
    idle      = (state == IDLE) || (state == FINISH);
    run_start = idle && start;
    tbl_we    = idle && exp_we;
    do_check  = (state == SETTLE) && settle_end;
    advance   = (state == CHECK) && !last_vec;
    finish    = (state == CHECK) && last_vec;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) exp_tbl[i] <= 4'h0;
      pla_in        <= 4'h0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_count     <= 8'h00;
      first_err_vec <= 4'h0;
      first_err_got <= 4'h0;
      signature     <= 4'h0;
      lfsr          <= LFSR_SEED;
      wait_cnt      <= 4'h0;
      vec_cnt       <= '0;
    end else begin
      if (tbl_we) exp_tbl[exp_addr] <= exp_data;

      if (run_start) begin
        busy          <= 1'b1;
        done          <= 1'b0;
        pass          <= 1'b0;
        err_count     <= 8'h00;
        first_err_vec <= 4'h0;
        first_err_got <= 4'h0;
        signature     <= 4'h0;
        lfsr          <= LFSR_SEED;
        vec_cnt       <= '0;
        wait_cnt      <= 4'h0;
        pla_in        <= 4'h0;
      end

      if (state == SETTLE) wait_cnt <= wait_cnt + 4'd1;

      // Sampling happens on the edge that leaves SETTLE, SETTLE_CYC edges after pla_in changed.
      if (do_check) begin
        signature <= {signature[2:0], signature[3] ^ signature[2]} ^ pla_out;
        if (mismatch) begin
          if (err_count != 8'hFF) err_count <= err_count + 8'd1;
          if (err_count == 8'h00) begin
            first_err_vec <= pla_in;
            first_err_got <= pla_out;
          end
        end
      end

      if (advance) begin
        vec_cnt  <= vec_cnt + 1'b1;
        wait_cnt <= 4'h0;
        if (vec_cnt < VW'(15)) begin
          pla_in <= vec_cnt[3:0] + 4'd1;
        end else begin
          pla_in <= lfsr;
          lfsr   <= lfsr_next;
        end
      end

      if (finish) begin
        busy   <= 1'b0;
        done   <= 1'b1;
        pass   <= (err_count == 8'h00);
        pla_in <= 4'h0;
      end
    end
  end

endmodule

// File: tb/tb_pla_bist_ctrl.sv
// tb/tb_pla_bist_ctrl.sv - directed bench for pla_bist_ctrl
// Two instances share host inputs: a short run (SETTLE 1, 16 random) and a long one (SETTLE 3, 300 random).
module tb_pla_bist_ctrl;

  localparam int SA = 1, RA = 16;
  localparam int SB = 3, RB = 300;
  localparam int LEN_A = (16 + RA) * (SA + 1);
  localparam int LEN_B = (16 + RB) * (SB + 1);

  logic       clk = 1'b0;
  logic       rst_n, exp_we, start;
  logic [3:0] exp_addr, exp_data;
  logic [3:0] pla_in_a, pla_out_a, pla_in_b, pla_out_b;
  logic       busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [7:0] err_a, err_b;
  logic [3:0] fv_a, fg_a, sig_a, fv_b, fg_b, sig_b;

  int n_chk = 0, n_fail = 0;
  int fault = 0;
  int cnt_a, cnt_b;
  logic [3:0] trace [64];

  always #5 clk = ~clk;

  pla_bist_ctrl #(.SETTLE_CYC(SA), .RAND_VECS(RA), .LFSR_SEED(4'b0001)) u_a (
    .clk(clk), .rst_n(rst_n), .exp_we(exp_we), .exp_addr(exp_addr), .exp_data(exp_data),
    .start(start), .pla_in(pla_in_a), .pla_out(pla_out_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .err_count(err_a), .first_err_vec(fv_a), .first_err_got(fg_a),
    .signature(sig_a));

  pla_bist_ctrl #(.SETTLE_CYC(SB), .RAND_VECS(RB), .LFSR_SEED(4'b0001)) u_b (
    .clk(clk), .rst_n(rst_n), .exp_we(exp_we), .exp_addr(exp_addr), .exp_data(exp_data),
    .start(start), .pla_in(pla_in_b), .pla_out(pla_out_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .err_count(err_b), .first_err_vec(fv_b), .first_err_got(fg_b),
    .signature(sig_b));

  function automatic logic [3:0] good(input logic [3:0] v);
    logic a, b, c, d;
    {a, b, c, d} = v;
    return {b | c, a & d, c ^ d, ~(a & b)};
  endfunction

  // fault 0: correct PLA, 1: F2 inverted for input 5 only, 2: outputs stuck at 0
  function automatic logic [3:0] pla_model(input logic [3:0] v, input int f);
    if (f == 2) return 4'h0;
    if (f == 1 && v == 4'h5) return good(v) ^ 4'b0100;
    return good(v);
  endfunction

  always_comb pla_out_a = pla_model(pla_in_a, fault);
  always_comb pla_out_b = pla_model(pla_in_b, fault);

  function automatic logic [3:0] model_sig(input int nv, input int f);
    logic [3:0] s, l, v;
    s = 4'h0;
    l = 4'b0001;
    for (int k = 0; k < nv; k++) begin
      if (k < 16) v = 4'(k);
      else begin
        v = l;
        l = {l[2:0], l[3] ^ l[2]};
      end
      s = {s[2:0], s[3] ^ s[2]} ^ pla_model(v, f);
    end
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic load_tbl(input bit all_f);
    for (int i = 0; i < 16; i++) begin
      exp_we = 1'b1;
      exp_addr = 4'(i);
      exp_data = all_f ? 4'hF : good(4'(i));
      @(negedge clk);
    end
    exp_we = 1'b0;
  endtask

  // dist_n >= 0 pulses start plus a corrupting table write at that cycle of the run.
  task automatic run(input int dist_n, input bit start_we, input logic [3:0] we_data);
    bit fin;
    start = 1'b1;
    if (start_we) begin
      exp_we = 1'b1;
      exp_addr = 4'h0;
      exp_data = we_data;
    end
    @(negedge clk);
    start = 1'b0;
    exp_we = 1'b0;
    cnt_a = 0;
    cnt_b = 0;
    fin = 1'b0;
    for (int n = 0; n < LEN_B + 100; n++) begin
      if (n < 64) trace[n] = pla_in_a;
      if (busy_a) cnt_a++;
      if (busy_b) cnt_b++;
      if (done_a && done_b && !busy_a && !busy_b) begin
        fin = 1'b1;
        break;
      end
      if (n == dist_n) begin
        start = 1'b1;
        exp_we = 1'b1;
        exp_addr = 4'h3;
        exp_data = ~good(4'h3);
      end else begin
        start = 1'b0;
        exp_we = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    exp_we = 1'b0;
    chk("run_completes", 32'(fin), 32'd1);
  endtask

  typedef struct {
    bit         all_f;
    int         fault;
    int         err_a;
    int         err_b;
    logic [3:0] first_vec;
    logic [3:0] first_got;
  } vec_t;

  task automatic verify(input string tag, input vec_t e);
    chk({tag, "_a_err"}, 32'(err_a), 32'(e.err_a));
    chk({tag, "_a_pass"}, 32'(pass_a), 32'(e.err_a == 0));
    chk({tag, "_a_first_vec"}, 32'(fv_a), 32'(e.first_vec));
    chk({tag, "_a_first_got"}, 32'(fg_a), 32'(e.first_got));
    chk({tag, "_a_sig"}, 32'(sig_a), 32'(model_sig(16 + RA, e.fault)));
    chk({tag, "_a_len"}, 32'(cnt_a), 32'(LEN_A));
    chk({tag, "_a_end_state"}, {pla_in_a, busy_a, done_a}, {4'h0, 1'b0, 1'b1});
    chk({tag, "_b_err"}, 32'(err_b), 32'(e.err_b));
    chk({tag, "_b_pass"}, 32'(pass_b), 32'(e.err_b == 0));
    chk({tag, "_b_first"}, {fv_b, fg_b}, {e.first_vec, e.first_got});
    chk({tag, "_b_sig"}, 32'(sig_b), 32'(model_sig(16 + RB, e.fault)));
    chk({tag, "_b_len"}, 32'(cnt_b), 32'(LEN_B));
    chk({tag, "_b_end_state"}, {pla_in_b, busy_b, done_b}, {4'h0, 1'b0, 1'b1});
  endtask

  vec_t vecs [3];
  logic [3:0] rand_exp [16];

  initial begin
    // 5 is hit once per 15-step LFSR period: A sees it twice, B 1+20 times; stuck-at rows saturate B.
    vecs[0] = '{all_f: 1'b0, fault: 0, err_a: 0,  err_b: 0,   first_vec: 4'h0, first_got: 4'h0};
    vecs[1] = '{all_f: 1'b0, fault: 1, err_a: 2,  err_b: 21,  first_vec: 4'h5, first_got: 4'hF};
    vecs[2] = '{all_f: 1'b1, fault: 2, err_a: 32, err_b: 255, first_vec: 4'h0, first_got: 4'h0};
    rand_exp = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                 4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};

    rst_n = 1'b0;
    exp_we = 1'b0;
    exp_addr = 4'h0;
    exp_data = 4'h0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_a", {busy_a, done_a, pass_a, err_a, fv_a, fg_a, sig_a, pla_in_a}, 32'h0);
    chk("reset_b", {busy_b, done_b, pass_b, err_b, fv_b, fg_b, sig_b, pla_in_b}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int r = 0; r < 3; r++) begin
      load_tbl(vecs[r].all_f);
      fault = vecs[r].fault;
      run(-1, 1'b0, 4'h0);
      verify($sformatf("row%0d", r), vecs[r]);
    end

    // Mid-run start and table write must be ignored.
    load_tbl(1'b0);
    fault = 0;
    run(10, 1'b0, 4'h0);
    verify("disturbed", vecs[0]);
    for (int k = 0; k < 32; k++) begin
      logic [3:0] ev;
      ev = (k < 16) ? 4'(k) : rand_exp[k - 16];
      chk($sformatf("order_vec%0d", k), {trace[2*k], trace[2*k+1]}, {ev, ev});
    end

    // Start and write in the same idle cycle: first CHECK must see the corrected entry 0.
    exp_we = 1'b1;
    exp_addr = 4'h0;
    exp_data = ~good(4'h0);
    @(negedge clk);
    exp_we = 1'b0;
    run(-1, 1'b1, good(4'h0));
    verify("start_with_write", vecs[0]);

    // Reset mid-run: outputs cleared at once, table cleared (all-zero PLA then matches).
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrun_reset_a", {busy_a, done_a, pass_a, err_a, fv_a, fg_a, sig_a, pla_in_a}, 32'h0);
    chk("midrun_reset_b", {busy_b, done_b, pass_b, err_b, fv_b, fg_b, sig_b, pla_in_b}, 32'h0);
    fault = 2;
    run(-1, 1'b0, 4'h0);
    verify("table_cleared", '{all_f: 1'b0, fault: 2, err_a: 0, err_b: 0,
                              first_vec: 4'h0, first_got: 4'h0});
    load_tbl(1'b0);
    fault = 0;
    run(-1, 1'b0, 4'h0);
    verify("after_reset", vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
